// File: rtl/wimax_pkg.sv
// Shared constants, address type and reference de-interleave mapping for the
// WiMAX QPSK block de-interleaver.
package wimax_pkg;

  localparam int NCBPS_QPSK = 192;
  localparam int INTLV_D    = 16;

  typedef logic [7:0] blk_addr_t;

  // Received index j lands at original index k = D*(j mod ROWS) + floor(j/ROWS).
  function automatic blk_addr_t deint_addr(input blk_addr_t j);
    int rows;
    int k;
    rows = NCBPS_QPSK / INTLV_D;
    k    = INTLV_D * (int'(j) % rows) + int'(j) / rows;
    return blk_addr_t'(k);
  endfunction

endpackage

// File: rtl/wimax_deint_addr_gen.sv
// Write-address generator: walks waddr = D*c + r incrementally (no multiplier),
// c cycling over the ROWS columns, r stepping once per column wrap.
module wimax_deint_addr_gen
  import wimax_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D
) (
  input  logic      clk_ref,
  input  logic      rst,
  input  logic      advance,
  output blk_addr_t waddr,
  output logic      wrap
);

  localparam int        ROWS   = NCBPS / D;
  localparam blk_addr_t C_LAST = blk_addr_t'(ROWS - 1);
  localparam blk_addr_t R_LAST = blk_addr_t'(D - 1);
  localparam blk_addr_t C_STEP = blk_addr_t'(D);

  blk_addr_t c;
  blk_addr_t r;
  blk_addr_t base;
  logic      c_last;

  assign c_last = (c == C_LAST);
  assign wrap   = advance && c_last && (r == R_LAST);
  assign waddr  = base + r;

  // base tracks D*c so the address is a single add of the row offset.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      c    <= '0;
      r    <= '0;
      base <= '0;
    end else if (advance) begin
      if (c_last) begin
        c    <= '0;
        base <= '0;
        r    <= (r == R_LAST) ? '0 : r + 8'd1;
      end else begin
        c    <= c + 8'd1;
        base <= base + C_STEP;
      end
    end
  end

endmodule

// File: rtl/wimax_deinterleaver.sv
// Ping-pong QPSK block de-interleaver: one bank fills at de-interleaved
// addresses while the other drains in order. Define WIMAX_DEINT_FRAME_FLAGS_EN
// to add sof_out/eof_out block framing outputs.
module wimax_deinterleaver
  import wimax_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out,
  input  logic ready_in
`ifdef WIMAX_DEINT_FRAME_FLAGS_EN
  ,
  output logic sof_out,
  output logic eof_out
`endif
);

  localparam blk_addr_t ADDR_LAST = blk_addr_t'(NCBPS - 1);

  logic [NCBPS-1:0] bank [2];
  logic [1:0]       full;
  logic             w_sel;
  logic             r_sel;
  blk_addr_t        waddr;
  blk_addr_t        raddr;
  blk_addr_t        wr_cnt;
  logic             wr_acc;
  logic             wr_last;
  logic             rd_acc;
  logic             rd_last;

  assign ready_out = !full[w_sel];
  assign wr_acc    = valid_in && ready_out;
  assign valid_out = full[r_sel];
  // Gated so the output is a clean 0 whenever nothing is being offered.
  assign data_out  = valid_out && bank[r_sel][raddr];
  assign rd_acc    = valid_out && ready_in;
  assign rd_last   = rd_acc && (raddr == ADDR_LAST);

`ifdef WIMAX_DEINT_FRAME_FLAGS_EN
  assign sof_out = valid_out && (raddr == '0);
  assign eof_out = valid_out && (raddr == ADDR_LAST);
`endif

  wimax_deint_addr_gen #(
    .NCBPS (NCBPS),
    .D     (D)
  ) u_addr_gen (
    .clk_ref (clk_ref),
    .rst     (rst),
    .advance (wr_acc),
    .waddr   (waddr),
    .wrap    (wr_last)
  );

  always_ff @(posedge clk_ref) begin
    if (wr_acc) begin
      bank[w_sel][waddr] <= data_in;
    end
  end

  // Set and clear can hit in one cycle only on different banks, so both apply.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      full  <= '0;
      w_sel <= 1'b0;
      r_sel <= 1'b0;
      raddr <= '0;
    end else begin
      if (wr_last) begin
        full[w_sel] <= 1'b1;
        w_sel       <= !w_sel;
      end
      if (rd_acc) begin
        if (rd_last) begin
          full[r_sel] <= 1'b0;
          r_sel       <= !r_sel;
          raddr       <= '0;
        end else begin
          raddr <= raddr + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (wr_acc) begin
      wr_cnt <= wr_last ? '0 : wr_cnt + 8'd1;
    end
  end

  a_waddr_map : assert property (@(posedge clk_ref) disable iff (rst)
    wr_acc |-> (waddr == deint_addr(wr_cnt)));

  a_no_same_bank : assert property (@(posedge clk_ref) disable iff (rst)
    !(wr_last && rd_last && (w_sel == r_sel)));

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Scoreboard bench: original blocks are interleaved with the transmit-side
// formula, fed in, and the in-order originals are expected at the output.
module tb_wimax_deinterleaver;

  localparam int N = 192;
  typedef logic [N-1:0] blk_t;   // bit k = original index k

  logic clk_ref  = 1'b0;
  logic rst      = 1'b1;
  logic data_in  = 1'b0;
  logic valid_in = 1'b0;
  logic ready_in = 1'b0;
  logic ready_out;
  logic data_out;
  logic valid_out;
`ifdef WIMAX_DEINT_FRAME_FLAGS_EN
  logic sof_out;
  logic eof_out;
`endif

  wimax_deinterleaver dut (
    .clk_ref   (clk_ref),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
`ifdef WIMAX_DEINT_FRAME_FLAGS_EN
    ,
    .sof_out   (sof_out),
    .eof_out   (eof_out)
`endif
  );

  always #5 clk_ref = ~clk_ref;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   nout = 0;
  int   oidx = 0;
  bit   track_rdy = 1'b0;
  int   rdy_drops = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, so a transfer seen here completes at the next edge.
  always @(negedge clk_ref) begin : mon
    logic e;
    if (!rst) begin
      if (track_rdy && !ready_out) rdy_drops++;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("data_out[%0d]", oidx), int'(data_out), int'(e));
        end
`ifdef WIMAX_DEINT_FRAME_FLAGS_EN
        check("sof_out", int'(sof_out), int'(oidx == 0));
        check("eof_out", int'(eof_out), int'(oidx == N - 1));
`endif
        oidx = (oidx == N - 1) ? 0 : oidx + 1;
        nout++;
      end
`ifdef WIMAX_DEINT_FRAME_FLAGS_EN
      else if (!valid_out) begin
        check("sof_idle", int'(sof_out), 0);
        check("eof_idle", int'(eof_out), 0);
      end
`endif
    end
  end

  // Transmit interleaver (QPSK): original k is sent at position 12*(k mod 16) + k/16.
  function automatic blk_t interleave(input blk_t orig);
    blk_t s;
    s = '0;
    for (int k = 0; k < N; k++) s[12 * (k % 16) + k / 16] = orig[k];
    return s;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < N; k++) b[k] = 1'($urandom_range(1, 0));
    return b;
  endfunction

  task automatic send_bit(input logic b);
    int t;
    data_in  = b;
    valid_in = 1'b1;
    t = 0;
    while (!ready_out && t < 2000) begin
      @(posedge clk_ref); #1;
      t++;
    end
    if (!ready_out) check("ready_out_timeout", 0, 1);
    @(posedge clk_ref); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_block(input blk_t orig);
    blk_t s;
    s = interleave(orig);
    for (int k = 0; k < N; k++) exp_q.push_back(orig[k]);
    for (int j = 0; j < N; j++) send_bit(s[j]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk_ref); #1;
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(posedge clk_ref);
    #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    blk_t orig;
    blk_t s;
    logic [191:0] pat;
    int n0;
    int early;

    // Reset state
    repeat (3) @(posedge clk_ref);
    #1;
    check("reset_ready_out", int'(ready_out), 1);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_data_out", int'(data_out), 0);
    rst = 1'b0;
    ready_in = 1'b1;

    // Single-1 mapping: stream bit j=1 -> out 16, j=12 -> out 1, j=191 -> out 191
    orig = '0; orig[16] = 1'b1;
    s = interleave(orig);
    check("single_j1_pos", int'(s[1]), 1);
    send_block(orig); drain();
    orig = '0; orig[1] = 1'b1;
    s = interleave(orig);
    check("single_j12_pos", int'(s[12]), 1);
    send_block(orig); drain();
    orig = '0; orig[191] = 1'b1;
    send_block(orig); drain();

    // Round trip of the reference pattern, MSB first
    pat = {2{96'hACBCD2114DAE1577C6DBF4C9}};
    for (int k = 0; k < N; k++) orig[k] = pat[191 - k];
    send_block(orig);
    check("latency_valid_out", int'(valid_out), 1);
    check("first_bit_msb", int'(data_out), int'(pat[191]));
    drain();

    // Continuous streaming: 6 back-to-back blocks
    n0 = nout;
    rdy_drops = 0;
    track_rdy = 1'b1;
    for (int b = 0; b < 6; b++) send_block(rand_blk());
    drain();
    track_rdy = 1'b0;
    check("stream_transfers", nout - n0, 6 * N);
    check("stream_ready_drops", rdy_drops, 0);

    // Backpressure: two blocks fill both banks
    ready_in = 1'b0;
    send_block(rand_blk());
    check("bp_ready_after_blk1", int'(ready_out), 1);
    send_block(rand_blk());
    check("bp_ready_after_383", int'(ready_out), 0);
    check("bp_valid_held", int'(valid_out), 1);
    ready_in = 1'b1;
    early = 0;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk_ref); #1;
      if (i < N && ready_out) early++;
    end
    check("bp_ready_early", early, 0);
    check("bp_ready_return", int'(ready_out), 1);
    send_block(rand_blk());
    drain();

    // Reset mid-operation: 100 bits in, 50 bits out
    ready_in = 1'b0;
    send_block(rand_blk());
    n0 = nout;
    orig = rand_blk();
    s = interleave(orig);
    for (int j = 0; j < 100; j++) begin
      ready_in = (j < 50);
      send_bit(s[j]);
    end
    ready_in = 1'b0;
    check("mid_outputs", nout - n0, 50);
    rst = 1'b1;
    @(posedge clk_ref); #1;
    rst = 1'b0;
    exp_q.delete();
    oidx = 0;
    check("mid_reset_valid_out", int'(valid_out), 0);
    check("mid_reset_ready_out", int'(ready_out), 1);
    ready_in = 1'b1;
    send_block(rand_blk());
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
